// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Seven-segment pattern constants (active-low gfedcba) and scan
//               capture FSM state type, shared by display driver and capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// ============================================================================
// Module      : seg_pattern_decode
// Description : Active-low segment pattern to {err, nibble}. Hex letters A-F
//               are decoded only when SEG_HEX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  // Unrecognised patterns (blank included) report nibble 0 with err set.
  always_comb begin
    o_nibble = 4'h0;
    o_err    = 1'b0;
    case (i_seg)
      SEG_0: o_nibble = 4'h0;
      SEG_1: o_nibble = 4'h1;
      SEG_2: o_nibble = 4'h2;
      SEG_3: o_nibble = 4'h3;
      SEG_4: o_nibble = 4'h4;
      SEG_5: o_nibble = 4'h5;
      SEG_6: o_nibble = 4'h6;
      SEG_7: o_nibble = 4'h7;
      SEG_8: o_nibble = 4'h8;
      SEG_9: o_nibble = 4'h9;
`ifdef SEG_HEX_EN
      SEG_A: o_nibble = 4'hA;
      SEG_B: o_nibble = 4'hB;
      SEG_C: o_nibble = 4'hC;
      SEG_D: o_nibble = 4'hD;
      SEG_E: o_nibble = 4'hE;
      SEG_F: o_nibble = 4'hF;
`endif
      default: o_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_capture.sv
// ============================================================================
// Module      : seg_scan_capture
// Description : Reconstructs per-digit values from a multiplexed active-low
//               seven-segment bus. Optional hex decode via SEG_HEX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    bus_fault
);

  localparam int c_cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   r_an_meta, r_an_sync, r_an_prev;
  logic [6:0]              r_seg_meta, r_seg_sync, r_seg_prev;
  logic [c_cnt_w-1:0]      r_cnt;
  scan_state_e             r_state;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_err;

  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_one_low;
  logic                    w_multi_low;
  logic                    w_changed;
  logic                    w_stable;
  logic [3:0]              w_nibble;
  logic                    w_err;
  logic [4*NUM_DIGITS-1:0] w_shadow_next;
  logic [NUM_DIGITS-1:0]   w_err_next;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  scan_state_e             w_rescan_state;

  // Synchronisers idle at all-ones so a released reset looks like a dark bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_meta  <= '1;
      r_an_sync  <= '1;
      r_an_prev  <= '1;
      r_seg_meta <= '1;
      r_seg_sync <= '1;
      r_seg_prev <= '1;
    end else begin
      r_an_meta  <= an;
      r_an_sync  <= r_an_meta;
      r_an_prev  <= r_an_sync;
      r_seg_meta <= seg;
      r_seg_sync <= r_seg_meta;
      r_seg_prev <= r_seg_sync;
    end
  end

  assign w_low          = ~r_an_sync;
  assign w_one_low      = $onehot(w_low);
  assign w_multi_low    = (w_low != '0) && !w_one_low;
  assign w_changed      = {r_an_sync, r_seg_sync} != {r_an_prev, r_seg_prev};
  assign w_stable       = !w_changed && (r_cnt == c_cnt_max);
  assign w_rescan_state = w_one_low ? ST_SETTLE : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || w_changed) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  seg_pattern_decode u_decode (
    .i_seg    (r_seg_sync),
    .o_nibble (w_nibble),
    .o_err    (w_err)
  );

  always_comb begin
    w_shadow_next = r_shadow;
    w_err_next    = r_shadow_err;
    w_seen_next   = r_seen | w_low;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_low[i]) begin
        w_shadow_next[4*i +: 4] = w_nibble;
        w_err_next[i]           = w_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_seen       <= '0;
      r_shadow     <= '0;
      r_shadow_err <= '0;
      digits       <= '0;
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      bus_fault    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (clear) begin
        r_state   <= ST_IDLE;
        r_seen    <= '0;
        bus_fault <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_multi_low && w_stable) bus_fault <= 1'b1;
            if (w_one_low) r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (w_changed) begin
              r_state <= w_rescan_state;
            end else if (r_cnt == c_cnt_max) begin
              r_state      <= ST_CAPTURE;
              r_shadow     <= w_shadow_next;
              r_shadow_err <= w_err_next;
              if (w_seen_next == '1) begin
                digits      <= w_shadow_next;
                digit_err   <= w_err_next;
                frame_valid <= 1'b1;
                r_seen      <= '0;
              end else begin
                r_seen <= w_seen_next;
              end
            end
          end
          // A pin change can already be visible during the capture cycle.
          ST_CAPTURE: r_state <= w_changed ? w_rescan_state : ST_HOLD;
          ST_HOLD: begin
            if (w_changed) r_state <= w_rescan_state;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart to the team's BCD/hex-to-seven-segment drivers. Observes a multiplexed, active-low seven-segment display bus (one-hot active-low anodes plus shared segment lines) and reconstructs the 4-bit value shown on every digit. Used on the bench board to read back what a display driver is emitting, and for self-check of the display path. Inputs are asynchronous pins and are synchronised internally.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1–8)
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (≥2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- an  in  NUM_DIGITS  anode lines, active-low, expected one-hot-low
- seg  in  7  segment lines, active-low, bit0=a … bit6=g
- clear  in  1  synchronous; discards partial frame
- digits  out  4*NUM_DIGITS  last complete frame; digit i at [4i+3:4i]
- digit_err  out  NUM_DIGITS  per-digit "unrecognised pattern" flags for the last frame
- frame_valid  out  1  one-cycle pulse when digits/digit_err update
- bus_fault  out  1  sticky; set when more than one anode is low after settling; cleared by clear

## Operation
- 2-flop synchroniser on an and seg; all logic below uses synchronised values.
- Stability counter: reset to 0 whenever the synchronised {an,seg} differs from the previous cycle; otherwise increment, saturating at STABLE_CYCLES-1.
- FSM:
  - IDLE: no anode low, or multiple low. Stable multiple-low sets bus_fault. Goes to SETTLE when exactly one anode is low.
  - SETTLE: counting. On counter == STABLE_CYCLES-1 → CAPTURE.
  - CAPTURE (one cycle): decode seg; write nibble and err bit into shadow slot for the active digit; set seen[i]. → HOLD.
  - HOLD: wait for any {an,seg} change → IDLE (if no/multiple anodes) or SETTLE.
- Decode: active-low gfedcba patterns 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9. Any other pattern, including blank 0x7F, → nibble 0, err bit 1.
- Frame completion: when a capture makes seen all-ones, copy shadow to digits/digit_err, pulse frame_valid, clear seen.
- A digit recaptured before the frame completes overwrites its shadow slot.
- clear: clears seen and bus_fault, FSM → IDLE, counter 0; digits/digit_err retained.
- If clear and frame completion coincide, clear wins: no frame_valid, outputs unchanged.

## Timing
- Reset: digits=0, digit_err=0, frame_valid=0, bus_fault=0, seen=0, shadow=0, FSM=IDLE, counter=0, synchronisers=all-ones (idle bus).
- Latency: a pin change first sampled at edge 0 is captured into shadow at edge STABLE_CYCLES+2. A completing capture updates digits and asserts frame_valid on that same edge.
- A pattern held for fewer than STABLE_CYCLES+1 synchronised cycles is never captured.
- Reset asserted mid-SETTLE or mid-frame aborts immediately. No partial frame survives.
- frame_valid is never high on two consecutive cycles.

## Configuration
- SEG_HEX_EN defined: additionally decode 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F with err=0.
- SEG_HEX_EN undefined: those six patterns are unrecognised (nibble 0, err 1).

## Structure
- Package seg_pkg: the 7-bit pattern constants (SEG_0…SEG_F, SEG_BLANK) and the FSM state enum, shared with the display-driver blocks.
- Sub-module seg_pattern_decode: combinational seg[6:0] → {err, nibble[3:0]}, containing the SEG_HEX_EN conditional. Scan/FSM/frame logic stays in seg_scan_capture.

## Test plan
- Reset: hold rst_n low with random pins → all outputs 0; after release with an=4'hF for 20 cycles → no frame_valid.
- Scan an=1110/0x24, 1101/0x30, 1011/0x19, 0111/0x79, 10 cycles each → single frame_valid, digits=16'h1432, digit_err=0.
- Glitch: insert an=1011/0x12 for STABLE_CYCLES cycles between valid digits → no capture of 5, frame still 16'h1432.
- Digit 2 shows 0x7F, others valid → digit_err=4'b0100, nibble 2 = 0; with a=0x08 on digit 0: SEG_HEX_EN → A, err0=0; undefined → 0, err0=1.
- Stable an=1100 for 10 cycles → bus_fault=1, no capture; clear → bus_fault=0.
- clear on the completing-capture edge → no frame_valid, digits unchanged; rst_n pulse mid-SETTLE → seen=0, next full scan produces a correct frame.
